// File: rtl/alu_cmd_issuer_if.sv
// Command, response and ALU-operand bundle between the issuer and its environment.
// master = issuer side, slave = command source / response sink / external ALU.
interface alu_cmd_issuer_if #(
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_kind;
    logic [3:0]        cmd_op;
    logic [2:0]        cmd_rd;
    logic [2:0]        cmd_rs1;
    logic [2:0]        cmd_rs2;
    logic [DATA_W-1:0] cmd_imm;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_zero;
    logic [2:0]        rsp_rd;

    modport master (
        input  cmd_valid, cmd_kind, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        output cmd_ready,
        output alu_a, alu_b, alu_op,
        input  alu_result, alu_zero,
        output rsp_valid, rsp_data, rsp_zero, rsp_rd,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_kind, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        input  cmd_ready,
        input  alu_a, alu_b, alu_op,
        output alu_result, alu_zero,
        input  rsp_valid, rsp_data, rsp_zero, rsp_rd,
        output rsp_ready
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Register-file command issuer for an external combinational ALU: IDLE -> EXEC -> RESP.
// Response one cycle after command accept; rsp_* held while rsp_ready low, no new command meanwhile.
module alu_cmd_issuer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_cmd_issuer_if.master bus,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] regs [8];

    logic              kind_q;
    logic [3:0]        op_q;
    logic [2:0]        rd_q;
    logic [2:0]        rs1_q;
    logic [2:0]        rs2_q;
    logic [DATA_W-1:0] imm_q;

    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_zero_q;
    logic [2:0]        rsp_rd_q;

    logic [DATA_W-1:0] wb_val;
    logic              wb_zero;

    // r0 is never written, but the read mux makes the hardwired zero explicit
    assign bus.alu_a  = (rs1_q == 3'd0) ? '0 : regs[rs1_q];
    assign bus.alu_b  = (rs2_q == 3'd0) ? '0 : regs[rs2_q];
    assign bus.alu_op = op_q;

    assign wb_val  = kind_q ? imm_q : bus.alu_result;
    assign wb_zero = kind_q ? (imm_q == '0) : bus.alu_zero;

    assign bus.cmd_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_rd    = rsp_rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
            kind_q      <= 1'b0;
            op_q        <= 4'd0;
            rd_q        <= 3'd0;
            rs1_q       <= 3'd0;
            rs2_q       <= 3'd0;
            imm_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_rd_q    <= 3'd0;
            done_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        kind_q <= bus.cmd_kind;
                        op_q   <= bus.cmd_op;
                        rd_q   <= bus.cmd_rd;
                        rs1_q  <= bus.cmd_rs1;
                        rs2_q  <= bus.cmd_rs2;
                        imm_q  <= bus.cmd_imm;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    // write-back lands before the next accept, so back-to-back hazards need no bypass
                    if (rd_q != 3'd0) begin
                        regs[rd_q] <= wb_val;
                    end
                    rsp_data_q  <= wb_val;
                    rsp_zero_q  <= wb_zero;
                    rsp_rd_q    <= rd_q;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        done_count  <= done_count + CNT_W'(1);
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
